branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64: number of table entries; power of two, 4..1024.
REQ-002 SHALL have parameter CTR_WID, default 2: saturating-counter width, 1..4.
REQ-003 SHALL have parameter GHR_WID, default 6: global history length, 1..16.
REQ-004 SHALL have parameter MODE, default BP_BIMODAL: index mode, BP_BIMODAL or BP_GSHARE.
REQ-005 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have rst, input, 1: reset; synchronous and active-high.
REQ-007 SHALL have pred_valid_i, input, 1: ID-stage lookup request.
REQ-008 SHALL have pred_pc_i, input, 32: PC of the instruction in ID.
REQ-009 SHALL have pred_taken_o, output, 1: predicted taken.
REQ-010 SHALL have pred_target_o, output, 32: predicted target.
REQ-011 SHALL have pred_ghr_o, output, GHR_WID: history snapshot, carried down the pipe with the branch.
REQ-012 SHALL have upd_valid_i, input, 1: EX-stage branch resolution.
REQ-013 SHALL have upd_pc_i, input, 32: PC of the resolved branch.
REQ-014 SHALL have upd_taken_i, input, 1: actual outcome.
REQ-015 SHALL have upd_target_i, input, 32: actual target.
REQ-016 SHALL have upd_mispredict_i, input, 1: prediction was wrong.
REQ-017 SHALL have upd_ghr_i, input, GHR_WID: snapshot returned with the branch.
REQ-018 SHALL have branch_cnt_o, output, 32: resolved-branch count.
REQ-019 SHALL have miss_cnt_o, output, 32: mispredict count.

Function
REQ-020 SHALL compute idx = pc[IDX+1:2], where IDX = log2(ENTRIES); in BP_GSHARE mode idx SHALL be XORed with the GHR, zero-extended or truncated to IDX bits.
REQ-021 SHALL compute tag = pc[31:IDX+2]; an entry hits when valid and its tag matches.
REQ-022 SHALL produce the lookup combinationally in the same cycle: pred_taken_o = pred_valid_i & hit & ctr[idx] MSB; pred_target_o = the BTB target on hit, else pred_pc_i+4.
REQ-023 SHALL drive pred_ghr_o with the current GHR register value, before any shift.
REQ-024 SHALL, on a rising edge with pred_valid_i=1 and no mispredict, shift the GHR speculatively: ghr <= {ghr[GHR_WID-2:0], pred_taken_o}.
REQ-025 SHALL, on a rising edge with upd_valid_i & upd_mispredict_i, restore the GHR: ghr <= {upd_ghr_i[GHR_WID-2:0], upd_taken_i}; this has priority over a simultaneous speculative shift.
REQ-026 SHALL, on upd_valid_i, index the counter with upd_pc_i, using upd_ghr_i in gshare mode; counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_WID-1.
REQ-027 SHALL, on upd_valid_i & upd_taken_i, write the BTB entry: valid=1, tag, upd_target_i; a not-taken outcome never allocates an entry.
REQ-028 SHALL NOT bypass a same-cycle update to a lookup of the same index; the lookup sees the pre-edge value.
REQ-029 SHALL increment branch_cnt_o on every upd_valid_i, and miss_cnt_o on upd_valid_i & upd_mispredict_i; both wrap modulo 2^32.
REQ-030 SHALL ignore upd_mispredict_i when upd_valid_i=0.

Reset
REQ-031 SHALL, on rst, clear all valid bits, set every counter to weak-not-taken (2^(CTR_WID-1)-1), and set GHR, branch_cnt_o and miss_cnt_o to 0.
REQ-032 SHALL give rst priority over any same-cycle update or shift; neither takes effect.
REQ-033 SHALL drive pred_taken_o=0 and pred_target_o=pred_pc_i+4 in the first cycle after reset.

Structure
REQ-034 SHALL place the bp_mode_e enum (BP_BIMODAL, BP_GSHARE) and the weak-not-taken constant function in the shared package Const_pkg.
REQ-035 SHALL use one sub-module, bp_sat_ctr: a parametrised CTR_WID saturating counter, instantiated per entry.
REQ-036 SHALL use no memory IP; all tables are flop arrays.

Verification
REQ-037 SHALL cover reset then lookup of 0x100 -> taken=0, target=0x104, counts 0.
REQ-038 SHALL cover bimodal: two taken updates for PC 0x100 -> target 0x200; next lookup -> taken=1, target=0x200.
REQ-039 SHALL cover saturation: five taken updates at CTR_WID=2 -> counter 3; one not-taken -> still predicts taken.
REQ-040 SHALL cover gshare: lookups with GHR 000000 and 000001 at the same PC -> distinct entries updated independently.
REQ-041 SHALL cover mispredict with upd_ghr_i=6'b101010, taken=1, plus a simultaneous pred_valid_i -> GHR=6'b010101, miss_cnt_o +1.
REQ-042 SHALL cover rst asserted together with upd_valid_i -> no BTB write, all counts 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and constants for the branch predictor
package Const_pkg;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    // Counter value that predicts not-taken but flips after one taken outcome
    function automatic int unsigned bp_weak_nt(input int unsigned ctr_wid);
        return (32'd1 << (ctr_wid - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - one saturating up/down prediction counter
module bp_sat_ctr
    import Const_pkg::*;
#(
    parameter int CTR_WID = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               taken_i,
    output logic [CTR_WID-1:0] ctr_o
);

    localparam logic [CTR_WID-1:0] CTR_MAX = '1;
    localparam logic [CTR_WID-1:0] CTR_WNT = CTR_WID'(bp_weak_nt(CTR_WID));

    logic [CTR_WID-1:0] ctr_d;
    logic [CTR_WID-1:0] ctr_q;

    // Step toward the observed outcome, holding at either end of the range
    always_comb begin
        ctr_d = ctr_q;
        if (en_i) begin
            if (taken_i) begin
                if (ctr_q != CTR_MAX) begin
                    ctr_d = ctr_q + 1'b1;
                end
            end else if (ctr_q != '0) begin
                ctr_d = ctr_q - 1'b1;
            end
        end
    end

    // Counter register; reset parks it at weak-not-taken
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= CTR_WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare direction predictor with BTB and stats
module branch_predictor
    import Const_pkg::*;
#(
    parameter int       ENTRIES = 64,
    parameter int       CTR_WID = 2,
    parameter int       GHR_WID = 6,
    parameter bp_mode_e MODE    = BP_BIMODAL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pred_valid_i,
    input  logic [31:0]        pred_pc_i,
    output logic               pred_taken_o,
    output logic [31:0]        pred_target_o,
    output logic [GHR_WID-1:0] pred_ghr_o,
    input  logic               upd_valid_i,
    input  logic [31:0]        upd_pc_i,
    input  logic               upd_taken_i,
    input  logic [31:0]        upd_target_i,
    input  logic               upd_mispredict_i,
    input  logic [GHR_WID-1:0] upd_ghr_i,
    output logic [31:0]        branch_cnt_o,
    output logic [31:0]        miss_cnt_o
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [GHR_WID-1:0] ghr_d;
    logic [GHR_WID-1:0] ghr_q;
    logic [31:0]        branch_cnt_d;
    logic [31:0]        branch_cnt_q;
    logic [31:0]        miss_cnt_d;
    logic [31:0]        miss_cnt_q;

    logic [ENTRIES-1:0] valid_d;
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_WID-1:0] ctr      [ENTRIES];

    logic [IDX-1:0]     pred_hist;
    logic [IDX-1:0]     upd_hist;
    logic [IDX-1:0]     pred_idx;
    logic [IDX-1:0]     upd_idx;
    logic [TAG_W-1:0]   pred_tag;
    logic [TAG_W-1:0]   upd_tag;
    logic               pred_hit;
    logic               unused_bits;

    // Shift one outcome into a history value, oldest bit falls off the top
    function automatic logic [GHR_WID-1:0] ghr_push(input logic [GHR_WID-1:0] h,
                                                     input logic b);
        return GHR_WID'({h, b});
    endfunction

    // Fit history to the index width: truncate long histories, zero-extend short ones
    generate
        if (GHR_WID >= IDX) begin : g_hist_trunc
            assign pred_hist = ghr_q[IDX-1:0];
            assign upd_hist  = upd_ghr_i[IDX-1:0];
        end else begin : g_hist_ext
            assign pred_hist = {{(IDX-GHR_WID){1'b0}}, ghr_q};
            assign upd_hist  = {{(IDX-GHR_WID){1'b0}}, upd_ghr_i};
        end
    endgenerate

    assign unused_bits = ^{upd_pc_i[1:0], ghr_q, upd_ghr_i};

    // Table indices and tags for the lookup and the resolving branch
    always_comb begin
        pred_idx = pred_pc_i[IDX+1:2];
        upd_idx  = upd_pc_i[IDX+1:2];
        if (MODE == BP_GSHARE) begin
            pred_idx = pred_idx ^ pred_hist;
            upd_idx  = upd_idx ^ upd_hist;
        end
        pred_tag = pred_pc_i[31:IDX+2];
        upd_tag  = upd_pc_i[31:IDX+2];
    end

    // Same-cycle lookup from registered state only; updates are never bypassed
    always_comb begin
        pred_hit      = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken_o  = pred_valid_i && pred_hit && ctr[pred_idx][CTR_WID-1];
        pred_target_o = pred_hit ? target_q[pred_idx] : (pred_pc_i + 32'd4);
    end

    assign pred_ghr_o   = ghr_q;
    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    // One counter per entry, stepped only when the resolving branch maps to it
    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
            bp_sat_ctr #(
                .CTR_WID (CTR_WID)
            ) u_ctr (
                .clk     (clk),
                .rst     (rst),
                .en_i    (upd_valid_i && (upd_idx == IDX'(i))),
                .taken_i (upd_taken_i),
                .ctr_o   (ctr[i])
            );
        end
    endgenerate

    // BTB allocation happens only on taken outcomes
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_valid_i && upd_taken_i) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target_i;
        end
    end

    // History repair on mispredict wins over the speculative shift; stats count resolutions
    always_comb begin
        ghr_d        = ghr_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = ghr_push(upd_ghr_i, upd_taken_i);
        end else if (pred_valid_i) begin
            ghr_d = ghr_push(ghr_q, pred_taken_o);
        end
        if (upd_valid_i) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (upd_mispredict_i) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // State registers; reset blocks any same-cycle write or shift
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            ghr_q        <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ghr_q        <= ghr_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized model-checked bench for bimodal and gshare predictors
module tb_branch_predictor;
    import Const_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mis;
    logic [5:0]  upd_ghr;

    logic        p_taken  [2];
    logic [31:0] p_target [2];
    logic [5:0]  p_ghr    [2];
    logic [31:0] b_cnt    [2];
    logic [31:0] m_cnt    [2];

    int checks   = 0;
    int failures = 0;

    // model state: [0] bimodal, [1] gshare
    int          m_ctr [2][64];
    bit          m_vld [2][64];
    logic [31:0] m_tag [2][64];
    logic [31:0] m_tgt [2][64];
    int          m_ghr [2];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .CTR_WID(2), .GHR_WID(6), .MODE(BP_BIMODAL)) u_bim (
        .clk(clk), .rst(rst), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_taken_o(p_taken[0]), .pred_target_o(p_target[0]), .pred_ghr_o(p_ghr[0]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_mispredict_i(upd_mis), .upd_ghr_i(upd_ghr),
        .branch_cnt_o(b_cnt[0]), .miss_cnt_o(m_cnt[0])
    );

    branch_predictor #(.ENTRIES(64), .CTR_WID(2), .GHR_WID(6), .MODE(BP_GSHARE)) u_gsh (
        .clk(clk), .rst(rst), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_taken_o(p_taken[1]), .pred_target_o(p_target[1]), .pred_ghr_o(p_ghr[1]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_mispredict_i(upd_mis), .upd_ghr_i(upd_ghr),
        .branch_cnt_o(b_cnt[1]), .miss_cnt_o(m_cnt[1])
    );

    function automatic int m_idx(input int m, input logic [31:0] pc, input int g);
        int i;
        i = int'((pc / 32'd4) % 32'd64);
        if (m == 1) i = i ^ (g % 64);
        return i;
    endfunction

    function automatic bit m_hit(input int m, input logic [31:0] pc);
        int i;
        i = m_idx(m, pc, m_ghr[m]);
        return m_vld[m][i] && (m_tag[m][i] == pc / 32'd256);
    endfunction

    function automatic bit exp_taken(input int m);
        return pred_valid && m_hit(m, pred_pc) && (m_ctr[m][m_idx(m, pred_pc, m_ghr[m])] >= 2);
    endfunction

    function automatic logic [31:0] exp_target(input int m);
        if (m_hit(m, pred_pc)) return m_tgt[m][m_idx(m, pred_pc, m_ghr[m])];
        return pred_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                m_vld[m][i] = 1'b0;
                m_ctr[m][i] = 1;
            end
            m_ghr[m] = 0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic idle();
        rst = 0; pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0;
        upd_taken = 0; upd_target = 0; upd_mis = 0; upd_ghr = 0;
    endtask

    // advance one clock, applying the rules to the model with pre-edge predictions
    task automatic tick();
        bit pt [2];
        int i;
        pt[0] = exp_taken(0);
        pt[1] = exp_taken(1);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (upd_valid) begin
                    i = m_idx(m, upd_pc, int'(upd_ghr));
                    if (upd_taken) begin
                        m_ctr[m][i] = (m_ctr[m][i] < 3) ? m_ctr[m][i] + 1 : 3;
                        m_vld[m][i] = 1'b1;
                        m_tag[m][i] = upd_pc / 32'd256;
                        m_tgt[m][i] = upd_target;
                    end else begin
                        m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
                    end
                end
                if (upd_valid && upd_mis) m_ghr[m] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 64;
                else if (pred_valid) m_ghr[m] = (m_ghr[m] * 2 + int'(pt[m])) % 64;
            end
            if (upd_valid) begin
                m_bc = m_bc + 1;
                if (upd_mis) m_mc = m_mc + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic [5:0] g);
        upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_ghr = g; upd_mis = 0;
        tick();
        upd_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        pred_valid = 1; pred_pc = 32'h100;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (p_taken[m] !== 1'b0) begin failures++; $display("FAIL reset_taken[%0d]: got %0b want 0", m, p_taken[m]); end
            checks++;
            if (p_target[m] !== 32'h104) begin failures++; $display("FAIL reset_target[%0d]: got %h want 00000104", m, p_target[m]); end
            checks++;
            if (b_cnt[m] !== 32'd0 || m_cnt[m] !== 32'd0) begin failures++; $display("FAIL reset_counts[%0d]: got %0d/%0d want 0/0", m, b_cnt[m], m_cnt[m]); end
            checks++;
            if (p_ghr[m] !== 6'd0) begin failures++; $display("FAIL reset_ghr[%0d]: got %b want 000000", m, p_ghr[m]); end
        end
        idle();
    endtask

    task automatic test_bimodal();
        do_reset();
        update(32'h100, 1, 32'h200, 6'd0);
        update(32'h100, 1, 32'h200, 6'd0);
        pred_valid = 1; pred_pc = 32'h100;
        #1;
        checks++;
        if (p_taken[0] !== 1'b1) begin failures++; $display("FAIL bimodal_taken: got %0b want 1", p_taken[0]); end
        checks++;
        if (p_target[0] !== 32'h200) begin failures++; $display("FAIL bimodal_target: got %h want 00000200", p_target[0]); end
        checks++;
        if (b_cnt[0] !== 32'd2) begin failures++; $display("FAIL bimodal_branch_cnt: got %0d want 2", b_cnt[0]); end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) update(32'h100, 1, 32'h200, 6'd0);
        update(32'h100, 0, 32'h0, 6'd0);
        pred_valid = 1; pred_pc = 32'h100;
        #1;
        checks++;
        if (p_taken[0] !== 1'b1) begin failures++; $display("FAIL sat_one_nt_taken: got %0b want 1", p_taken[0]); end
        idle();
        update(32'h100, 0, 32'h0, 6'd0);
        pred_valid = 1; pred_pc = 32'h100;
        #1;
        checks++;
        if (p_taken[0] !== 1'b0 || p_target[0] !== 32'h200) begin
            failures++; $display("FAIL sat_two_nt: got taken=%0b target=%h want 0/00000200", p_taken[0], p_target[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_gshare();
        do_reset();
        update(32'h100, 1, 32'h300, 6'b000000);
        update(32'h100, 1, 32'h400, 6'b000001);
        update(32'h100, 0, 32'h0,   6'b000001);
        pred_valid = 1; pred_pc = 32'h100;
        #1;
        checks++;
        if (p_ghr[1] !== 6'b000000 || p_taken[1] !== 1'b1 || p_target[1] !== 32'h300) begin
            failures++; $display("FAIL gshare_ghr0: got ghr=%b taken=%0b target=%h want 000000/1/00000300", p_ghr[1], p_taken[1], p_target[1]);
        end
        tick();
        #1;
        checks++;
        if (p_ghr[1] !== 6'b000001 || p_taken[1] !== 1'b0 || p_target[1] !== 32'h400) begin
            failures++; $display("FAIL gshare_ghr1: got ghr=%b taken=%0b target=%h want 000001/0/00000400", p_ghr[1], p_taken[1], p_target[1]);
        end
        tick();
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        pred_valid = 1; pred_pc = 32'h100;
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h200;
        upd_mis = 1; upd_ghr = 6'b101010;
        tick();
        idle();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (p_ghr[m] !== 6'b010101) begin failures++; $display("FAIL mispredict_ghr[%0d]: got %b want 010101", m, p_ghr[m]); end
            checks++;
            if (m_cnt[m] !== 32'd1) begin failures++; $display("FAIL mispredict_miss_cnt[%0d]: got %0d want 1", m, m_cnt[m]); end
        end
    endtask

    task automatic test_rst_update();
        update(32'h500, 1, 32'h900, 6'd0);
        rst = 1; pred_valid = 1; pred_pc = 32'h500;
        upd_valid = 1; upd_pc = 32'h500; upd_taken = 1; upd_target = 32'h900; upd_mis = 1; upd_ghr = 6'h3f;
        tick();
        idle();
        pred_valid = 1; pred_pc = 32'h500;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (p_target[m] !== 32'h504 || p_taken[m] !== 1'b0) begin
                failures++; $display("FAIL rst_upd_btb[%0d]: got taken=%0b target=%h want 0/00000504", m, p_taken[m], p_target[m]);
            end
            checks++;
            if (b_cnt[m] !== 32'd0 || m_cnt[m] !== 32'd0 || p_ghr[m] !== 6'd0) begin
                failures++; $display("FAIL rst_upd_state[%0d]: got cnt=%0d miss=%0d ghr=%b want 0/0/0", m, b_cnt[m], m_cnt[m], p_ghr[m]);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 49) == 0);
            pred_valid = $urandom_range(0, 1);
            pred_pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            upd_valid  = $urandom_range(0, 1);
            upd_pc     = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            upd_taken  = $urandom_range(0, 1);
            upd_target = $urandom & 32'hfffffffc;
            upd_mis    = ($urandom_range(0, 3) == 0);
            upd_ghr    = 6'($urandom_range(0, 63));
            #1;
            for (int m = 0; m < 2; m++) begin
                bad = 0;
                if (p_taken[m] !== exp_taken(m)) bad = 1;
                if (p_target[m] !== exp_target(m)) bad = 1;
                if (p_ghr[m] !== 6'(m_ghr[m])) bad = 1;
                if (b_cnt[m] !== m_bc || m_cnt[m] !== m_mc) bad = 1;
                checks++;
                if (bad != 0) begin
                    failures++;
                    $display("FAIL random[%0d] cyc %0d: got taken=%0b tgt=%h ghr=%0d cnt=%0d miss=%0d want %0b/%h/%0d/%0d/%0d",
                             m, c, p_taken[m], p_target[m], p_ghr[m], b_cnt[m], m_cnt[m],
                             exp_taken(m), exp_target(m), m_ghr[m], m_bc, m_mc);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_bimodal();
        test_saturation();
        test_gshare();
        test_mispredict();
        test_rst_update();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
